// File: rtl/rib_arbiter.sv
// Two-master bus arbiter: shares one memory slave between the ex data port and the
// instruction fetch port, with fair tie-breaking and a per-transaction timeout.
module rib_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ex_req_i,
    input  logic        ex_we_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    output logic [31:0] ex_rdata_o,
    output logic        ex_ack_o,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic [31:0] s_rdata_i,
    input  logic        s_ack_i,

    output logic [2:0]  hold_flag_o,
    output logic        bus_err_o
);

    localparam logic [2:0] HoldNone = 3'b000;
    localparam logic [2:0] HoldIf   = 3'b010;
    localparam logic [2:0] HoldId   = 3'b011;
    localparam logic [4:0] CntLast  = 5'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGntEx,
        StGntIf
    } state_e;

    state_e      r_state;
    logic        r_last_if;
    logic [4:0]  r_cnt;

    logic        w_own_ex;
    logic        w_own_if;
    logic        w_active;
    logic        w_done;
    logic        w_timeout;
    logic        w_ack;
    logic [31:0] w_rdata;

    assign w_own_ex = (r_state == StGntEx);
    assign w_own_if = (r_state == StGntIf);

    // A reset cycle never forwards or completes a transaction.
    assign w_active  = ~rst & ((w_own_ex & ex_req_i) | (w_own_if & if_req_i));
    assign w_done    = w_active & s_ack_i;
    assign w_timeout = w_active & ~s_ack_i & (r_cnt == CntLast);
    assign w_ack     = w_done | w_timeout;
    assign w_rdata   = w_done ? s_rdata_i : 32'h0;

    always_comb begin
        s_req_o    = w_active;
        s_we_o     = 1'b0;
        s_addr_o   = 32'h0;
        s_wdata_o  = 32'h0;
        ex_ack_o   = 1'b0;
        ex_rdata_o = 32'h0;
        if_ack_o   = 1'b0;
        if_rdata_o = 32'h0;
        if (w_own_ex) begin
            s_we_o     = ex_we_i;
            s_addr_o   = ex_addr_i;
            s_wdata_o  = ex_wdata_i;
            ex_ack_o   = w_ack;
            ex_rdata_o = w_rdata;
        end else if (w_own_if) begin
            s_addr_o   = if_addr_i;
            if_ack_o   = w_ack;
            if_rdata_o = w_rdata;
        end
    end

    assign bus_err_o   = w_timeout;
    assign hold_flag_o = (if_req_i && !if_ack_o) ? (HoldIf | HoldId) : HoldNone;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= 5'd0;
            r_last_if <= 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_cnt <= 5'd0;
                    if (ex_req_i && (!if_req_i || r_last_if)) begin
                        r_state <= StGntEx;
                    end else if (if_req_i) begin
                        r_state <= StGntIf;
                    end
                end
                StGntEx: begin
                    if (!ex_req_i || w_timeout) begin
                        r_state   <= StIdle;
                        r_last_if <= 1'b0;
                        r_cnt     <= 5'd0;
                    end else if (s_ack_i) begin
                        // Completing master is excluded: only the other one can follow.
                        r_state   <= if_req_i ? StGntIf : StIdle;
                        r_last_if <= 1'b0;
                        r_cnt     <= 5'd0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                StGntIf: begin
                    if (!if_req_i || w_timeout) begin
                        r_state   <= StIdle;
                        r_last_if <= 1'b1;
                        r_cnt     <= 5'd0;
                    end else if (s_ack_i) begin
                        r_state   <= ex_req_i ? StGntEx : StIdle;
                        r_last_if <= 1'b1;
                        r_cnt     <= 5'd0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rib_arbiter.sv
// Bench for rib_arbiter: directed scenarios plus random traffic, every cycle compared
// against a transaction-level model of who owns the bus and how long it has waited.
module tb_rib_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_req_i, ex_we_i;
    logic [31:0] ex_addr_i, ex_wdata_i, ex_rdata_o;
    logic        ex_ack_o;
    logic        if_req_i;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        if_ack_o;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic        s_ack_i;
    logic [2:0]  hold_flag_o;
    logic        bus_err_o;

    always #5 clk = ~clk;

    rib_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ex_req_i(ex_req_i), .ex_we_i(ex_we_i), .ex_addr_i(ex_addr_i),
        .ex_wdata_i(ex_wdata_i), .ex_rdata_o(ex_rdata_o), .ex_ack_o(ex_ack_o),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_ack_o(if_ack_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i),
        .hold_flag_o(hold_flag_o), .bus_err_o(bus_err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Model: owner 0 = nobody, 1 = ex, 2 = fetch; waited = granted cycles without ack.
    int   m_owner;
    int   m_waited;
    bit   m_last_if;
    logic exp_ex_ack, exp_if_ack;
    logic        obs_s_req, obs_s_we, obs_ex_ack, obs_if_ack, obs_bus_err;
    logic [31:0] obs_s_addr, obs_s_wdata, obs_ex_rdata, obs_if_rdata;
    logic [2:0]  obs_hold;

    task automatic cycle();
        logic        own_req, active, done, expired;
        logic [31:0] e_rdata, e_addr, e_wdata;
        logic        e_we;
        @(negedge clk);
        own_req = (m_owner == 1) ? ex_req_i : ((m_owner == 2) ? if_req_i : 1'b0);
        active  = !rst && own_req;
        done    = active && s_ack_i;
        expired = active && !s_ack_i && (m_waited == TIMEOUT - 1);
        e_rdata = done ? s_rdata_i : 32'h0;
        e_addr  = (m_owner == 1) ? ex_addr_i : ((m_owner == 2) ? if_addr_i : 32'h0);
        e_we    = (m_owner == 1) ? ex_we_i : 1'b0;
        e_wdata = (m_owner == 1) ? ex_wdata_i : 32'h0;
        exp_ex_ack = (m_owner == 1) && (done || expired);
        exp_if_ack = (m_owner == 2) && (done || expired);
        check_val("s_req", s_req_o, active);
        check_val("s_we", s_we_o, e_we);
        check_val("s_addr", s_addr_o, e_addr);
        check_val("s_wdata", s_wdata_o, e_wdata);
        check_val("ex_ack", ex_ack_o, exp_ex_ack);
        check_val("ex_rdata", ex_rdata_o, exp_ex_ack ? e_rdata : 32'h0);
        check_val("if_ack", if_ack_o, exp_if_ack);
        check_val("if_rdata", if_rdata_o, exp_if_ack ? e_rdata : 32'h0);
        check_val("bus_err", bus_err_o, expired);
        check_val("hold", hold_flag_o, (if_req_i && !exp_if_ack) ? 32'd3 : 32'd0);
        obs_s_req = s_req_o;     obs_s_we = s_we_o;         obs_s_addr = s_addr_o;
        obs_s_wdata = s_wdata_o; obs_ex_ack = ex_ack_o;     obs_ex_rdata = ex_rdata_o;
        obs_if_ack = if_ack_o;   obs_if_rdata = if_rdata_o; obs_bus_err = bus_err_o;
        obs_hold = hold_flag_o;
        @(posedge clk);
        if (rst) begin
            m_owner = 0; m_waited = 0; m_last_if = 1'b1;
        end else if (m_owner == 0) begin
            m_waited = 0;
            if (ex_req_i && if_req_i) m_owner = m_last_if ? 1 : 2;
            else if (ex_req_i)        m_owner = 1;
            else if (if_req_i)        m_owner = 2;
        end else if (!own_req || done || expired) begin
            bit other_req;
            int other;
            other     = 3 - m_owner;
            other_req = (other == 1) ? ex_req_i : if_req_i;
            m_last_if = (m_owner == 2);
            m_waited  = 0;
            m_owner   = (done && other_req) ? other : 0;
        end else begin
            m_waited++;
        end
        #1;
    endtask

    task automatic quiet();
        ex_req_i = 0; ex_we_i = 0; ex_addr_i = 0; ex_wdata_i = 0;
        if_req_i = 0; if_addr_i = 0; s_ack_i = 0; s_rdata_i = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int dead;
        m_owner = 0; m_waited = 0; m_last_if = 1'b1;
        quiet();
        rst = 1'b1;
        @(posedge clk); #1;
        do_reset();
        check_val("reset_s_req", obs_s_req, 0);

        // Lone fetch, slave answers two cycles after the request is forwarded
        if_req_i = 1; if_addr_i = 32'h100;
        cycle(); check_val("fetch_c0_hold", obs_hold, 3); check_val("fetch_c0_sreq", obs_s_req, 0);
        cycle(); check_val("fetch_c1_sreq", obs_s_req, 1); check_val("fetch_c1_addr", obs_s_addr, 32'h100);
        cycle(); check_val("fetch_c2_hold", obs_hold, 3);
        s_ack_i = 1; s_rdata_i = 32'h13;
        cycle(); check_val("fetch_c3_ack", obs_if_ack, 1); check_val("fetch_c3_rdata", obs_if_rdata, 32'h13);
        check_val("fetch_c3_hold", obs_hold, 0);
        quiet(); cycle();

        // Simultaneous ex write and fetch, zero-wait slave
        do_reset();
        ex_req_i = 1; ex_we_i = 1; ex_addr_i = 32'h2000; ex_wdata_i = 32'hDEADBEEF;
        if_req_i = 1; if_addr_i = 32'h200; s_ack_i = 1; s_rdata_i = 32'h55;
        cycle(); check_val("tie_c0_sreq", obs_s_req, 0);
        cycle(); check_val("tie_c1_exack", obs_ex_ack, 1); check_val("tie_c1_we", obs_s_we, 1);
        check_val("tie_c1_wdata", obs_s_wdata, 32'hDEADBEEF); check_val("tie_c1_ifack", obs_if_ack, 0);
        ex_req_i = 0;
        cycle(); check_val("tie_c2_ifack", obs_if_ack, 1); check_val("tie_c2_addr", obs_s_addr, 32'h200);
        quiet(); cycle();

        // Both requesting continuously: grants alternate
        do_reset();
        ex_req_i = 1; if_req_i = 1; s_ack_i = 1;
        cycle();
        for (int k = 0; k < 8; k++) begin
            cycle();
            check_val("alt_ex", obs_ex_ack, (k % 2) == 0);
            check_val("alt_if", obs_if_ack, (k % 2) == 1);
        end
        quiet(); cycle(); cycle();

        // Slave never answers: timeout in the 16th granted cycle
        do_reset();
        ex_req_i = 1; ex_addr_i = 32'h300;
        cycle();
        n = 1;
        cycle();
        while (!obs_ex_ack && n < 40) begin
            n++;
            cycle();
        end
        check_val("to_cycle", n, TIMEOUT);
        check_val("to_err", obs_bus_err, 1);
        check_val("to_rdata", obs_ex_rdata, 0);
        ex_req_i = 0;
        cycle(); check_val("to_sreq_after", obs_s_req, 0);

        // Reset mid-grant discards the transaction
        do_reset();
        ex_req_i = 1; if_req_i = 1; if_addr_i = 32'h240;
        cycle();
        cycle(); check_val("rst_c1_sreq", obs_s_req, 1);
        rst = 1;
        cycle(); check_val("rst_c2_exack", obs_ex_ack, 0);
        rst = 0; ex_req_i = 0; s_ack_i = 1;
        cycle(); check_val("rst_c3_exack", obs_ex_ack, 0); check_val("rst_c3_sreq", obs_s_req, 0);
        s_ack_i = 0;
        cycle(); check_val("rst_c4_sreq", obs_s_req, 1); check_val("rst_c4_addr", obs_s_addr, 32'h240);
        quiet(); cycle(); cycle();

        // Owner drops its request before ack
        do_reset();
        ex_req_i = 1; ex_addr_i = 32'h400;
        cycle();
        cycle(); check_val("drop_c1_sreq", obs_s_req, 1);
        ex_req_i = 0; if_req_i = 1; if_addr_i = 32'h500;
        cycle(); check_val("drop_c2_exack", obs_ex_ack, 0); check_val("drop_c2_sreq", obs_s_req, 0);
        cycle(); check_val("drop_c3_sreq", obs_s_req, 0);
        cycle(); check_val("drop_c4_sreq", obs_s_req, 1); check_val("drop_c4_addr", obs_s_addr, 32'h500);
        quiet(); cycle(); cycle();

        // Random traffic
        dead = 0;
        for (int c = 0; c < 4000; c++) begin
            if (exp_ex_ack || (ex_req_i && $urandom_range(49) == 0) ||
                (!ex_req_i && $urandom_range(2) == 0)) begin
                ex_req_i   = exp_ex_ack ? 1'($urandom_range(1)) : !ex_req_i;
                ex_we_i    = 1'($urandom_range(1));
                ex_addr_i  = $urandom;
                ex_wdata_i = $urandom;
            end
            if (exp_if_ack || (if_req_i && $urandom_range(49) == 0) ||
                (!if_req_i && $urandom_range(2) == 0)) begin
                if_req_i  = exp_if_ack ? 1'($urandom_range(1)) : !if_req_i;
                if_addr_i = $urandom;
            end
            if (dead > 0) begin
                dead--;
                s_ack_i = 0;
            end else begin
                s_ack_i = ($urandom_range(2) == 0);
                if ($urandom_range(149) == 0) dead = 25;
            end
            s_rdata_i = $urandom;
            rst = ($urandom_range(199) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
